accuracy_tracker: RTL and testbench

- Synthesizable on-chip accuracy monitor, downstream of the DNN output stage.
- Collects the streamed ideal-output beats (y_out) for each training case and assembles them into a full ideal vector.
- At the end of each case, compares that vector with the thresholded all-neuron output (a_out_alln).
- Maintains a sliding-window correct count, total correct, case counter and epoch counter, so accuracy is observable without testbench-side bookkeeping.

---
 rtl/accuracy_tracker.sv | 187 ++++++++++++++++++
 tb/tb_accuracy_tracker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/accuracy_tracker.sv
// accuracy_tracker
//   On-chip accuracy monitor placed after the DNN output stage. Ideal-output
//   beats are assembled into a full N_OUT-bit ideal vector. On each case_end
//   that vector is compared with the thresholded output a_out. The block
//   keeps a sliding-window correct count, a running total, a case count and
//   an epoch number.
//
// Ports
//   clk           : system clock
//   reset         : synchronous, active-high; has priority over all inputs
//   y_valid/y_in  : ideal-output beat (Y_W bits, beat k -> neurons k*Y_W..)
//   a_out         : thresholded actual output, sampled on case_end
//   case_end      : single-cycle strobe on the last cycle of a case
//   correct       : result of the most recently evaluated case
//   result_valid  : one-cycle pulse when results/counters have updated
//   recent        : correct cases among the last WINDOW cases
//   total_correct : correct cases since reset
//   num_train     : cases evaluated since reset
//   epoch         : current epoch, starting at 1
//   epoch_done    : pulse with result_valid on the last case of an epoch
//   beat_err      : sticky, a case had the wrong number of beats
//   done          : sticky, num_train reached TOTAL_CASES
module accuracy_tracker #(
   parameter int N_OUT           = 16,
   parameter int Y_W             = 1,
   parameter int WINDOW          = 1000,
   parameter int CASES_PER_EPOCH = 10000,
   parameter int TOTAL_CASES     = 100000,
   parameter int CNT_W           = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             y_valid,
   input  logic [Y_W-1:0]                   y_in,
   input  logic [N_OUT-1:0]                 a_out,
   input  logic                             case_end,
   output logic                             correct,
   output logic                             result_valid,
   output logic [$clog2(WINDOW+1)-1:0]      recent,
   output logic [CNT_W-1:0]                 total_correct,
   output logic [CNT_W-1:0]                 num_train,
   output logic [15:0]                      epoch,
   output logic                             epoch_done,
   output logic                             beat_err,
   output logic                             done
);

   localparam int B     = N_OUT / Y_W;
   localparam int BC_W  = $clog2(B + 1);
   localparam int REC_W = $clog2(WINDOW + 1);
   localparam int PTR_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int EC_W  = (CASES_PER_EPOCH > 1) ? $clog2(CASES_PER_EPOCH) : 1;

   logic [BC_W-1:0]   cnt_q, cnt_d;
   logic [N_OUT-1:0]  ideal_q, ideal_d;
   logic [WINDOW-1:0] hist_q, hist_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [REC_W-1:0]  recent_q, recent_d;
   logic [CNT_W-1:0]  total_q, total_d;
   logic [CNT_W-1:0]  num_q, num_d;
   logic [EC_W-1:0]   ecnt_q, ecnt_d;
   logic [15:0]       epoch_q, epoch_d;
   logic              correct_q, correct_d;
   logic              rv_q, rv_d;
   logic              ed_q, ed_d;
   logic              berr_q, berr_d;
   logic              done_q, done_d;

   // Combinational view of the current cycle, with a same-cycle beat folded in
   logic              beat_take;
   logic              beat_drop;
   logic              eval;
   logic              result;
   logic [BC_W-1:0]   cnt_eff;
   logic [N_OUT-1:0]  ideal_eff;

   always_comb begin
      beat_take = y_valid && (cnt_q < BC_W'(B));
      beat_drop = y_valid && (cnt_q == BC_W'(B));
      eval      = case_end && !done_q;

      ideal_eff = ideal_q;
      cnt_eff   = cnt_q;
      if (beat_take) begin
         ideal_eff[int'(cnt_q)*Y_W +: Y_W] = y_in;
         cnt_eff = cnt_q + 1'b1;
      end

      // Dropped excess beats do not count, so a case with extra beats is
      // still judged on its first B beats (the drop itself flags beat_err).
      result = eval && (cnt_eff == BC_W'(B)) && (a_out == ideal_eff);
   end

   always_comb begin
      cnt_d     = cnt_eff;
      ideal_d   = ideal_eff;
      hist_d    = hist_q;
      ptr_d     = ptr_q;
      recent_d  = recent_q;
      total_d   = total_q;
      num_d     = num_q;
      ecnt_d    = ecnt_q;
      epoch_d   = epoch_q;
      correct_d = correct_q;
      rv_d      = 1'b0;
      ed_d      = 1'b0;
      berr_d    = berr_q;
      done_d    = done_q;

      // Once done, beats are still absorbed but no longer raise beat_err
      if (beat_drop && !done_q)
         berr_d = 1'b1;

      if (eval) begin
         cnt_d     = '0;
         ideal_d   = '0;
         correct_d = result;
         rv_d      = 1'b1;
         if (cnt_eff != BC_W'(B))
            berr_d = 1'b1;

         // Sliding window: the slot being overwritten leaves the count
         recent_d       = recent_q - REC_W'(hist_q[ptr_q]) + REC_W'(result);
         hist_d[ptr_q]  = result;
         ptr_d          = (ptr_q == PTR_W'(WINDOW - 1)) ? '0 : ptr_q + 1'b1;

         total_d = total_q + CNT_W'(result);
         num_d   = num_q + 1'b1;

         if (ecnt_q == EC_W'(CASES_PER_EPOCH - 1)) begin
            ecnt_d  = '0;
            epoch_d = epoch_q + 16'd1;
            ed_d    = 1'b1;
         end else begin
            ecnt_d = ecnt_q + 1'b1;
         end

         if (num_d == CNT_W'(TOTAL_CASES))
            done_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         ideal_q   <= '0;
         hist_q    <= '0;
         ptr_q     <= '0;
         recent_q  <= '0;
         total_q   <= '0;
         num_q     <= '0;
         ecnt_q    <= '0;
         epoch_q   <= 16'd1;
         correct_q <= 1'b0;
         rv_q      <= 1'b0;
         ed_q      <= 1'b0;
         berr_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         ideal_q   <= ideal_d;
         hist_q    <= hist_d;
         ptr_q     <= ptr_d;
         recent_q  <= recent_d;
         total_q   <= total_d;
         num_q     <= num_d;
         ecnt_q    <= ecnt_d;
         epoch_q   <= epoch_d;
         correct_q <= correct_d;
         rv_q      <= rv_d;
         ed_q      <= ed_d;
         berr_q    <= berr_d;
         done_q    <= done_d;
      end
   end

   assign correct       = correct_q;
   assign result_valid  = rv_q;
   assign recent        = recent_q;
   assign total_correct = total_q;
   assign num_train     = num_q;
   assign epoch         = epoch_q;
   assign epoch_done    = ed_q;
   assign beat_err      = berr_q;
   assign done          = done_q;

endmodule

// File: tb/tb_accuracy_tracker.sv
module tb_accuracy_tracker;

   localparam int N_OUT = 16;
   localparam int WIN   = 4;
   localparam int CPE   = 3;
   localparam int TOT   = 6;

   logic        clk = 1'b0;
   logic        reset;
   logic        y_valid;
   logic [0:0]  y_in;
   logic [15:0] a_out;
   logic        case_end;
   logic        correct, result_valid, epoch_done, beat_err, done;
   logic [2:0]  recent;
   logic [31:0] total_correct, num_train;
   logic [15:0] epoch;

   always #5 clk = ~clk;

   accuracy_tracker #(
      .N_OUT(N_OUT), .Y_W(1), .WINDOW(WIN), .CASES_PER_EPOCH(CPE),
      .TOTAL_CASES(TOT), .CNT_W(32)
   ) dut (
      .clk(clk), .reset(reset), .y_valid(y_valid), .y_in(y_in),
      .a_out(a_out), .case_end(case_end), .correct(correct),
      .result_valid(result_valid), .recent(recent),
      .total_correct(total_correct), .num_train(num_train), .epoch(epoch),
      .epoch_done(epoch_done), .beat_err(beat_err), .done(done)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: beats collected into a bit list, history as a queue of
   // the last WIN results, accuracy counters as plain integers.
   bit          m_bits[$];
   int          m_hist[$];
   int          m_total, m_num, m_epoch, m_ecase;
   bit          m_correct, m_rv, m_ed, m_berr, m_done;

   function automatic int m_recent();
      int s = 0;
      foreach (m_hist[i]) s += m_hist[i];
      return s;
   endfunction

   task automatic model_reset();
      m_bits.delete();
      m_hist.delete();
      for (int i = 0; i < WIN; i++) m_hist.push_back(0);
      m_total = 0; m_num = 0; m_epoch = 1; m_ecase = 0;
      m_correct = 0; m_rv = 0; m_ed = 0; m_berr = 0; m_done = 0;
   endtask

   task automatic model_step(input bit yv, input bit yi, input bit ce,
                             input logic [15:0] ao);
      logic [15:0] vec;
      bit res;
      m_rv = 0;
      m_ed = 0;
      if (yv) begin
         if (m_bits.size() < N_OUT) m_bits.push_back(yi);
         else if (!m_done) m_berr = 1;
      end
      if (ce && !m_done) begin
         vec = '0;
         foreach (m_bits[i]) vec[i] = m_bits[i];
         res = (m_bits.size() == N_OUT) && (ao == vec);
         if (m_bits.size() != N_OUT) m_berr = 1;
         m_hist.push_back(int'(res));
         void'(m_hist.pop_front());
         m_total += int'(res);
         m_num++;
         m_ecase++;
         if (m_ecase == CPE) begin
            m_ecase = 0;
            m_epoch++;
            m_ed = 1;
         end
         if (m_num == TOT) m_done = 1;
         m_correct = res;
         m_rv = 1;
         m_bits.delete();
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("correct",       32'(correct),      32'(m_correct));
      chk("result_valid",  32'(result_valid), 32'(m_rv));
      chk("recent",        32'(recent),       32'(m_recent()));
      chk("total_correct", total_correct,     32'(m_total));
      chk("num_train",     num_train,         32'(m_num));
      chk("epoch",         32'(epoch),        32'(m_epoch));
      chk("epoch_done",    32'(epoch_done),   32'(m_ed));
      chk("beat_err",      32'(beat_err),     32'(m_berr));
      chk("done",          32'(done),         32'(m_done));
   endtask

   task automatic cyc(input bit rst, input bit yv, input bit yi, input bit ce,
                      input logic [15:0] ao);
      @(negedge clk);
      reset    = rst;
      y_valid  = yv;
      y_in     = yi;
      case_end = ce;
      a_out    = ao;
      @(posedge clk);
      if (rst) model_reset();
      else model_step(yv, yi, ce, ao);
      #1;
      check_all();
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 16'h0);
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0, 16'h0);
   endtask

   // nb beats of ideal (beats beyond 16 are random); case_end either on the
   // last beat or on a separate following cycle
   task automatic run_case(input logic [15:0] ideal, input int nb,
                           input logic [15:0] ao, input bit ce_sep,
                           input bit gaps);
      bit yi;
      bit ce;
      for (int k = 0; k < nb; k++) begin
         if (gaps && ($urandom % 4 == 0)) idle();
         yi = (k < N_OUT) ? ideal[k] : 1'($urandom % 2);
         ce = !ce_sep && (k == nb - 1);
         cyc(0, 1, yi, ce, ao);
      end
      if (ce_sep || nb == 0) cyc(0, 0, 0, 1, ao);
   endtask

   initial begin
      logic [15:0] iv, av;
      int          nb, r;
      reset = 1'b1; y_valid = 1'b0; y_in = '0; case_end = 1'b0; a_out = '0;
      model_reset();

      // Reset state
      do_reset();
      chk("rst_epoch", 32'(epoch), 32'd1);
      idle();

      // Basic match
      run_case(16'h0008, 16, 16'h0008, 0, 0);
      chk("t1_correct", 32'(correct), 32'd1);
      chk("t1_recent", 32'(recent), 32'd1);
      chk("t1_num", num_train, 32'd1);
      idle();

      // Mismatch
      run_case(16'h0008, 16, 16'h0010, 0, 0);
      chk("t2_correct", 32'(correct), 32'd0);
      chk("t2_total", total_correct, 32'd1);
      chk("t2_num", num_train, 32'd2);

      // Window wrap: 1,1,1,1,0,0 -> recent 1,2,3,4,3,2
      do_reset();
      for (int c = 0; c < 6; c++) begin
         av = (c < 4) ? 16'h1234 : 16'h4321;
         run_case(16'h1234, 16, av, 0, 0);
         chk("t3_recent", 32'(recent), (c < 4) ? 32'(c + 1) : 32'(7 - c));
      end
      chk("t3_done", 32'(done), 32'd1);

      // Short case
      do_reset();
      run_case(16'h00F0, 15, 16'h00F0, 1, 0);
      chk("t4_short_correct", 32'(correct), 32'd0);
      chk("t4_short_berr", 32'(beat_err), 32'd1);
      // Long case: 17th beat dropped, first 16 still compared
      do_reset();
      run_case(16'hA5C3, 17, 16'hA5C3, 0, 0);
      chk("t4_long_correct", 32'(correct), 32'd1);
      chk("t4_long_berr", 32'(beat_err), 32'd1);

      // Epoch and stop
      do_reset();
      for (int c = 1; c <= 6; c++) begin
         run_case(16'h8001, 16, 16'h8001, 0, 1);
         if (c == 3) begin
            chk("t5_ed3", 32'(epoch_done), 32'd1);
            chk("t5_epoch3", 32'(epoch), 32'd2);
         end
      end
      chk("t5_ed6", 32'(epoch_done), 32'd1);
      chk("t5_epoch6", 32'(epoch), 32'd3);
      chk("t5_done", 32'(done), 32'd1);
      run_case(16'h8001, 16, 16'h8001, 0, 0);
      chk("t5_rv7", 32'(result_valid), 32'd0);
      chk("t5_num7", num_train, 32'd6);
      // Extra beats after done must not raise beat_err
      for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0, 16'h0);
      chk("t5_berr_frozen", 32'(beat_err), 32'd0);

      // Reset mid-case
      do_reset();
      for (int k = 0; k < 8; k++) cyc(0, 1, 1, 0, 16'h0);
      do_reset();
      chk("t6_num_rst", num_train, 32'd0);
      run_case(16'h5A5A, 16, 16'h5A5A, 0, 0);
      chk("t6_correct", 32'(correct), 32'd1);
      chk("t6_num", num_train, 32'd1);
      chk("t6_berr", 32'(beat_err), 32'd0);

      // Randomized episodes against the model
      for (int e = 0; e < 20; e++) begin
         do_reset();
         for (int c = 0; c < 8; c++) begin
            r  = $urandom % 8;
            nb = (r == 0) ? 15 : (r == 1) ? 17 : (r == 2) ? 0 : 16;
            iv = 16'($urandom);
            av = ($urandom % 2 == 1) ? iv : (iv ^ (16'h1 << ($urandom % 16)));
            run_case(iv, nb, av, ($urandom % 3 == 0), 1'($urandom % 2));
            if ($urandom % 2 == 1) idle();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
